// File: rtl/ltc2666_arb_pkg.sv
// Shared types and constants for the LTC2666 message arbiter.
// Payload widths, FSM state encoding and default watchdog limit.
package ltc2666_arb_pkg;

  localparam int CMD_W          = 4;
  localparam int MASK_W         = 8;
  localparam int DATA_W         = 16;
  localparam int TIMEOUT_CC_DEF = 4096;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/ltc2666_rr_pick.sv
// Combinational round-robin pick: first valid requester at or
// above ptr_i, wrapping past N-1 back to 0.
module ltc2666_rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] sel_o,
  output logic          any_o
);

  int j;

  // Scan from the far end so the lowest offset from ptr_i wins.
  always_comb begin
    sel_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      if (valid_i[j]) begin
        sel_o = IW'(j);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ltc2666_msg_arbiter.sv
// Round-robin arbiter feeding one LTC2666 DAC message controller.
// Optional watchdog enabled by defining LTC_ARB_WATCHDOG_EN.
module ltc2666_msg_arbiter
  import ltc2666_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int TIMEOUT_CC = TIMEOUT_CC_DEF,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [CMD_W*N_REQ-1:0]  req_cmd_i,
  input  logic [MASK_W*N_REQ-1:0] req_chan_mask_i,
  input  logic [DATA_W*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_done_o,
  output logic [N_REQ-1:0]        req_err_o,
  output logic                    msg_valid_o,
  input  logic                    msg_ready_i,
  output logic [CMD_W-1:0]        msg_cmd_o,
  output logic [MASK_W-1:0]       msg_chan_mask_o,
  output logic [DATA_W-1:0]       msg_data_o,
  input  logic                    done_i,
  input  logic                    err_illegal_i,
  input  logic                    err_echo_i,
  output logic [IW-1:0]           grant_id_o,
  output logic                    active_o,
  output logic                    timeout_o,
  input  logic                    clear_i
);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IW-1:0]     sel;
  logic              any_valid;
  logic [IW-1:0]     grant_nxt;

  ltc2666_rr_pick #(.N(N_REQ)) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (rr_q),
    .sel_o   (sel),
    .any_o   (any_valid)
  );

  assign grant_nxt = (grant_q == IW'(N_REQ - 1)) ?
                     '0 : grant_q + 1'b1;

`ifdef LTC_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CC);
  logic [CW-1:0] cnt_q;
  logic          tmo_q;
  logic          tmo_w;

  // A done_i in the expiry cycle still completes normally.
  assign tmo_w = (state_q != IDLE) &&
                 (cnt_q == CW'(TIMEOUT_CC - 1)) &&
                 !((state_q == WAIT_DONE) && done_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
      if (tmo_w)        tmo_q <= 1'b1;
      else if (clear_i) tmo_q <= 1'b0;
    end
  end

  assign timeout_o = tmo_q;
`else
  logic unused_wd;
  assign unused_wd = clear_i | (TIMEOUT_CC == 0);
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    cmd_d       = cmd_q;
    mask_d      = mask_q;
    data_d      = data_q;
    req_ready_o = '0;
    req_done_o  = '0;
    req_err_o   = '0;
    msg_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready_o[sel] = 1'b1;
          grant_d = sel;
          cmd_d   = req_cmd_i[sel*CMD_W +: CMD_W];
          mask_d  = req_chan_mask_i[sel*MASK_W +: MASK_W];
          data_d  = req_data_i[sel*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        msg_valid_o = 1'b1;
        if (msg_ready_i) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_i) begin
          req_done_o[grant_q] = 1'b1;
          req_err_o[grant_q]  = err_illegal_i | err_echo_i;
          rr_d    = grant_nxt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef LTC_ARB_WATCHDOG_EN
    if (tmo_w) begin
      msg_valid_o         = 1'b0;
      req_done_o          = '0;
      req_err_o           = '0;
      req_done_o[grant_q] = 1'b1;
      req_err_o[grant_q]  = 1'b1;
      rr_d                = grant_nxt;
      state_d             = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cmd_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign msg_cmd_o       = cmd_q;
  assign msg_chan_mask_o = mask_q;
  assign msg_data_o      = data_q;
  assign grant_id_o      = grant_q;
  assign active_o        = (state_q != IDLE);

endmodule

// File: tb/tb_ltc2666_msg_arbiter.sv
// Directed bench for ltc2666_msg_arbiter (4 requesters).
// Watchdog sequence runs only when LTC_ARB_WATCHDOG_EN is defined.
module tb_ltc2666_msg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_cmd;
  logic [31:0] req_mask;
  logic [63:0] req_data;
  logic [3:0]  req_done;
  logic [3:0]  req_err;
  logic        msg_valid;
  logic        msg_ready;
  logic [3:0]  msg_cmd;
  logic [7:0]  msg_mask;
  logic [15:0] msg_data;
  logic        done;
  logic        err_ill;
  logic        err_echo;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout;
  logic        clear;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ltc2666_msg_arbiter #(.N_REQ(4), .TIMEOUT_CC(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_cmd_i       (req_cmd),
    .req_chan_mask_i (req_mask),
    .req_data_i      (req_data),
    .req_done_o      (req_done),
    .req_err_o       (req_err),
    .msg_valid_o     (msg_valid),
    .msg_ready_i     (msg_ready),
    .msg_cmd_o       (msg_cmd),
    .msg_chan_mask_o (msg_mask),
    .msg_data_o      (msg_data),
    .done_i          (done),
    .err_illegal_i   (err_ill),
    .err_echo_i      (err_echo),
    .grant_id_o      (grant_id),
    .active_o        (active),
    .timeout_o       (timeout),
    .clear_i         (clear)
  );

  typedef struct {
    int          id;
    logic [3:0]  cmd;
    logic [7:0]  mask;
    logic [15:0] data;
    logic        ill;
    logic        echo;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input logic [3:0] c,
                         input logic [7:0] m, input logic [15:0] d);
    req_valid[k]        = 1'b1;
    req_cmd[4*k +: 4]   = c;
    req_mask[8*k +: 8]  = m;
    req_data[16*k +: 16] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_txn(input vec_t v);
    req_valid = '0;
    set_req(v.id, v.cmd, v.mask, v.data);
    smp();
    chk("ready", 32'(req_ready), 32'(v.exp_rdy));
    step();
    req_valid = '0;
    req_cmd   = '1;
    req_mask  = '1;
    req_data  = '1;
    msg_ready = 1'b1;
    smp();
    chk("msg_valid", 32'(msg_valid), 1);
    chk("msg_cmd", 32'(msg_cmd), 32'(v.cmd));
    chk("msg_mask", 32'(msg_mask), 32'(v.mask));
    chk("msg_data", 32'(msg_data), 32'(v.data));
    chk("grant_id", 32'(grant_id), v.id);
    step();
    msg_ready = 1'b0;
    done      = 1'b1;
    err_ill   = v.ill;
    err_echo  = v.echo;
    smp();
    chk("msg_valid_wait", 32'(msg_valid), 0);
    chk("done", 32'(req_done), 32'(v.exp_rdy));
    chk("err", 32'(req_err), 32'(v.exp_err));
    step();
    done     = 1'b0;
    err_ill  = 1'b0;
    err_echo = 1'b0;
    smp();
    chk("done_1cyc", 32'(req_done), 0);
    chk("err_1cyc", 32'(req_err), 0);
    chk("idle", 32'(active), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ord[5];
    int cyc_at[5];
    int ngr;
    int idx;
    int exp_ord[5];
    exp_ord = '{0, 1, 2, 3, 0};

    tbl[0] = '{2, 4'h3, 8'h01, 16'h8000, 1'b0, 1'b0, 4'b0100, 4'b0000};
    tbl[1] = '{1, 4'hA, 8'hF0, 16'h1234, 1'b0, 1'b1, 4'b0010, 4'b0010};
    tbl[2] = '{0, 4'h1, 8'hFF, 16'hFFFF, 1'b1, 1'b0, 4'b0001, 4'b0001};
    tbl[3] = '{3, 4'hF, 8'h80, 16'h0001, 1'b0, 1'b0, 4'b1000, 4'b0000};
    tbl[4] = '{1, 4'h0, 8'h00, 16'h0000, 1'b0, 1'b0, 4'b0010, 4'b0000};

    rst = 1'b1; req_valid = '0; req_cmd = '0; req_mask = '0;
    req_data = '0; msg_ready = 1'b0; done = 1'b0; err_ill = 1'b0;
    err_echo = 1'b0; clear = 1'b0;
    step();
    step();
    smp();
    chk("rst_active", 32'(active), 0);
    chk("rst_msg_valid", 32'(msg_valid), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_payload", {12'h0, msg_cmd, msg_data}, 0);
    chk("rst_mask", 32'(msg_mask), 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) do_txn(tbl[i]);

    // Stall in ISSUE with done_i asserted: it must be ignored.
    set_req(3, 4'h6, 8'h5A, 16'hBEEF);
    step();
    req_valid = '0;
    done      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("stall_valid", 32'(msg_valid), 1);
      chk("stall_data", 32'(msg_data), 32'h0000BEEF);
      chk("stall_done_ign", 32'(req_done), 0);
      step();
    end
    msg_ready = 1'b1;
    step();
    msg_ready = 1'b0;
    smp();
    chk("stall_done", 32'(req_done), 32'b1000);
    chk("stall_mask", 32'(msg_mask), 32'h5A);
    step();
    done = 1'b0;
`ifndef LTC_ARB_WATCHDOG_EN
    smp();
    chk("timeout_tied", 32'(timeout), 0);
    step();
`endif

    // All requesters valid from reset: strict rotation with wrap.
    do_reset();
    for (int k = 0; k < 4; k++)
      set_req(k, 4'(k), 8'(k + 1), 16'(16'h1000 * (k + 1)));
    msg_ready = 1'b1;
    done      = 1'b1;
    ngr = 0;
    for (int c = 0; c < 40 && ngr < 5; c++) begin
      smp();
      if (req_ready != 0) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (req_ready[k]) idx = k;
        ord[ngr]    = idx;
        cyc_at[ngr] = c;
        ngr++;
      end
      step();
    end
    chk("rr_count", ngr, 5);
    for (int i = 0; i < ngr; i++) chk("rr_order", ord[i], exp_ord[i]);
    for (int i = 1; i < ngr; i++)
      chk("rr_spacing", cyc_at[i] - cyc_at[i-1], 3);
    smp();
    chk("rr_payload", 32'(msg_data), 32'h00001000);
    step();
    req_valid = '0;
    msg_ready = 1'b0;
    done      = 1'b0;

    // Reset in WAIT_DONE abandons the transaction.
    do_reset();
    set_req(2, 4'h3, 8'h01, 16'h8000);
    step();
    req_valid = '0;
    msg_ready = 1'b1;
    step();
    msg_ready = 1'b0;
    smp();
    chk("wd_active", 32'(active), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    smp();
    chk("ab_active", 32'(active), 0);
    chk("ab_grant", 32'(grant_id), 0);
    chk("ab_msg_valid", 32'(msg_valid), 0);
    step();
    step();
    done = 1'b1;
    smp();
    chk("ab_late_done", 32'(req_done), 0);
    chk("ab_still_idle", 32'(active), 0);
    step();
    done = 1'b0;
    req_valid = 4'b1010;
    smp();
    chk("ab_rr_ptr0", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    msg_ready = 1'b1;
    step();
    msg_ready = 1'b0;
    done = 1'b1;
    smp();
    chk("ab_next_done", 32'(req_done), 32'b0010);
    step();
    done = 1'b0;

`ifdef LTC_ARB_WATCHDOG_EN
    do_reset();
    set_req(1, 4'h2, 8'h03, 16'h0F0F);
    step();
    req_valid = '0;
    msg_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      smp();
      if (k == 15) begin
        chk("wdt_done", 32'(req_done), 32'b0010);
        chk("wdt_err", 32'(req_err), 32'b0010);
        chk("wdt_valid_drop", 32'(msg_valid), 0);
        clear = 1'b1;
      end else begin
        chk("wdt_early", 32'(req_done), 0);
        chk("wdt_flag_low", 32'(timeout), 0);
      end
      step();
      msg_ready = 1'b0;
    end
    clear = 1'b0;
    smp();
    chk("wdt_wins_clear", 32'(timeout), 1);
    chk("wdt_idle", 32'(active), 0);
    step();
    smp();
    chk("wdt_sticky", 32'(timeout), 1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    smp();
    chk("wdt_cleared", 32'(timeout), 0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ltc2666_msg_arbiter.md
LTC2666_MSG_ARBITER -- requirements
Module: ltc2666_msg_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CC, default 4096, giving the watchdog limit in clk_i cycles.
REQ-003 clk_i  in  1  single clock; all logic is on the rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 req_valid_i  in  N_REQ  per-requester message request.
REQ-006 req_ready_o  out  N_REQ  one-cycle capture pulse to the granted requester.
REQ-007 req_cmd_i  in  4*N_REQ  packed commands; requester k uses bits [4k+3:4k].
REQ-008 req_chan_mask_i  in  8*N_REQ  packed channel masks.
REQ-009 req_data_i  in  16*N_REQ  packed DAC codes.
REQ-010 req_done_o  out  N_REQ  one-cycle completion pulse.
REQ-011 req_err_o  out  N_REQ  error qualifier; valid only while req_done_o is high.
REQ-012 msg_valid_o / msg_ready_i  out/in  1/1  downstream message handshake to the DAC controller.
REQ-013 msg_cmd_o, msg_chan_mask_o, msg_data_o  out  4/8/16  captured message.
REQ-014 done_i, err_illegal_i, err_echo_i  in  1/1/1  controller completion and error flags.
REQ-015 grant_id_o  out  $clog2(N_REQ)  index of the current or last granted requester.
REQ-016 active_o  out  1  high in any state other than IDLE.
REQ-017 timeout_o, clear_i  out/in  1/1  sticky watchdog flag and its clear.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT_DONE.
REQ-019 IDLE with any req_valid_i high SHALL do all of the following in the same cycle: select the first valid requester scanning upward (with wrap) from rr_ptr, pulse req_ready_o[sel], register cmd/mask/data and grant_id_o, and go to ISSUE.
REQ-020 ISSUE SHALL hold msg_valid_o=1 with stable payload until msg_valid_o&&msg_ready_i, then go to WAIT_DONE; msg_valid_o SHALL be 0 in all other states.
REQ-021 WAIT_DONE on done_i SHALL pulse req_done_o[grant] and set req_err_o[grant]=err_illegal_i|err_echo_i for one cycle, set rr_ptr=(grant+1) mod N_REQ, and go to IDLE.
REQ-022 done_i in IDLE or ISSUE SHALL be ignored.
REQ-023 Minimum spacing SHALL be one cycle from capture to msg_valid_o; after done_i, the next capture SHALL occur in the following cycle (back-to-back).
REQ-024 Requests arriving while not IDLE SHALL wait; the block SHALL never drop or duplicate a message.
REQ-025 With all N_REQ requesters continuously valid, grants SHALL rotate strictly, and rr_ptr wrap from N_REQ-1 to 0 SHALL be exercised.
REQ-026 Payload registers SHALL be unaffected when a requester drops req_valid_i after capture.
REQ-027 When clear_i and a timeout event occur in the same cycle, the timeout SHALL win (timeout_o=1).

Reset
REQ-028 On rst_i the block SHALL enter IDLE, with rr_ptr=0, grant_id_o=0, and msg_valid_o, req_ready_o, req_done_o, req_err_o, active_o, timeout_o all 0, and the payload registers at 0.
REQ-029 rst_i asserted in ISSUE or WAIT_DONE SHALL abandon the transaction with no req_done_o pulse, and a later done_i SHALL be ignored.

Configuration
REQ-030 Macro LTC_ARB_WATCHDOG_EN defined: a counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE or WAIT_DONE; on reaching TIMEOUT_CC-1 the block SHALL pulse req_done_o[grant] with req_err_o=1, set timeout_o, drop msg_valid_o, and go to IDLE.
REQ-031 Macro LTC_ARB_WATCHDOG_EN undefined: the block SHALL have no counter logic and SHALL tie timeout_o to 0, and clear_i SHALL be unused.

Structure
REQ-032 Package ltc2666_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT_DONE), the CMD_W=4, MASK_W=8 and DATA_W=16 constants, and the default TIMEOUT_CC.
REQ-033 The round-robin pick SHALL be a combinational sub-module ltc2666_rr_pick (inputs valid vector and rr_ptr; outputs sel index and any_valid).

Verification
REQ-034 Bench: only req 2 valid with cmd=3, mask=0x01, data=0x8000 -> req_ready_o=0b0100; next cycle msg_valid_o=1 with that payload; done_i -> req_done_o=0b0100, req_err_o=0.
REQ-035 Bench: reqs 0..3 valid continuously from reset -> grant order 0,1,2,3,0.
REQ-036 Bench: msg_ready_i held low for 10 cycles in ISSUE -> payload stable and msg_valid_o high throughout.
REQ-037 Bench: done_i with err_echo_i=1 for req 1 -> req_err_o[1]=1 for one cycle only.
REQ-038 Bench: rst_i asserted in WAIT_DONE, then done_i 3 cycles later -> no req_done_o pulse, state IDLE, rr_ptr=0.
REQ-039 Bench (LTC_ARB_WATCHDOG_EN, TIMEOUT_CC=16): done_i never arrives -> 16 cycles after ISSUE entry, req_done_o and req_err_o pulse and timeout_o=1 until clear_i.
